// File: rtl/l2_wr_pkg.sv
// Shared types and constants for the L2 write controller.
package l2_wr_pkg;

  localparam int L2_ADDR_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/l2_wr_fifo2.sv
// Two-entry FIFO decoupling NoC beat arrival from L2 write grants.
module l2_wr_fifo2 #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_wr_ctrl.sv
// Moves a commanded number of NoC beats into L2, stepping an external address unit per write.
module l2_wr_ctrl
  import l2_wr_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_W-1:0]     cmd_beats,
  input  logic                 noc_in_valid,
  output logic                 noc_in_ready,
  input  logic [DATA_W-1:0]    noc_in_data,
  output logic                 addr_mu_initial_en,
  output logic                 addr_mu_valid,
  input  logic [L2_ADDR_W-1:0] addr_mu_addr,
  output logic                 l2_cs,
  output logic                 l2_we,
  output logic [L2_ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0]    l2_wdata,
  input  logic                 l2_gnt,
  output logic                 busy,
  output logic                 done
);

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  beats_q;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              cmd_fire;
  logic              push;
  logic              wr_fire;
  logic              last_wr;

  assign cmd_ready          = (state_q == ST_IDLE);
  assign busy               = ~cmd_ready;
  assign done               = (state_q == ST_DONE);
  assign addr_mu_initial_en = (state_q == ST_INIT);
  assign cmd_fire           = cmd_valid & cmd_ready;

  // Registered full only, so a pop in the same cycle never opens room for a push.
  assign noc_in_ready = ((state_q == ST_INIT) || (state_q == ST_RUN))
                        && !fifo_full && (acc_cnt_q < beats_q);
  assign push         = noc_in_valid & noc_in_ready;

  // Address and head stay put during a stall: no pop, no address advance.
  assign l2_cs         = (state_q == ST_RUN) && !fifo_empty;
  assign l2_we         = l2_cs;
  assign l2_addr       = l2_cs ? addr_mu_addr : '0;
  assign l2_wdata      = l2_cs ? fifo_head : '0;
  assign wr_fire       = l2_cs & l2_gnt;
  assign addr_mu_valid = wr_fire;
  assign last_wr       = wr_fire && (wr_cnt_q == beats_q - CNT_W'(1));

  l2_wr_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (wr_fire),
    .wdata (noc_in_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire) state_d = (cmd_beats == '0) ? ST_DONE : ST_INIT;
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  if (last_wr) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      beats_q   <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        beats_q   <= cmd_beats;
        acc_cnt_q <= '0;
        wr_cnt_q  <= '0;
      end else begin
        if (push)    acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        if (wr_fire) wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/l2_wr_ctrl.md
L2_WR_CTRL -- requirements
Module: l2_wr_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 128, L2 write-data width; CNT_W, default 16, beat-counter width.
REQ-002 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  transfer command valid.
- cmd_ready  out  1  command accepted when both high.
- cmd_beats  in  CNT_W  beats in transfer.
- noc_in_valid  in  1  NoC data beat valid.
- noc_in_ready  out  1  NoC beat accepted when both high.
- noc_in_data  in  DATA_W  NoC beat payload.
- addr_mu_initial_en  out  1  one-cycle start pulse to the address unit.
- addr_mu_valid  out  1  advance the address unit by one step.
- addr_mu_addr  in  13  current L2 address; registered in the address unit, valid the cycle after initial_en or valid.
- l2_cs  out  1  L2 request.
- l2_we  out  1  L2 write enable.
- l2_addr  out  13  L2 address.
- l2_wdata  out  DATA_W  L2 write data.
- l2_gnt  in  1  L2 accepts the request this cycle.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL implement FSM IDLE, INIT, RUN, DONE.
REQ-004 SHALL drive cmd_ready=1 only in IDLE.
REQ-005 On cmd handshake SHALL latch cmd_beats, clear the accepted-beat and written-beat counters, and go to DONE if cmd_beats==0, otherwise to INIT.
REQ-006 In INIT (exactly one cycle) SHALL drive addr_mu_initial_en=1, then go to RUN; addr_mu_initial_en SHALL be 0 in every other state.
REQ-007 SHALL buffer NoC beats in a 2-entry FIFO.
REQ-008 SHALL drive noc_in_ready=1 only in INIT or RUN, with the FIFO not full and accepted count < latched beats. Accepting more beats than commanded is impossible.
REQ-009 In RUN with the FIFO non-empty SHALL drive l2_cs=1, l2_we=1, l2_addr=addr_mu_addr, l2_wdata=FIFO head. All four SHALL be 0 otherwise.
REQ-010 SHALL hold l2_addr and l2_wdata stable while l2_cs=1 and l2_gnt=0.
REQ-011 A write completes when l2_cs&l2_gnt; in that cycle the block SHALL pop the FIFO, set addr_mu_valid=1 (combinational, same cycle), and increment the written count.
REQ-012 addr_mu_valid SHALL be 0 in all other cycles.
REQ-013 When the completing write is the last (written count+1 == beats), SHALL go to DONE next cycle.
REQ-014 DONE SHALL last one cycle with done=1, then go to IDLE. A new command SHALL be accepted no earlier than the IDLE cycle after DONE.
REQ-015 FIFO push and pop in the same cycle SHALL keep the occupancy unchanged. A full FIFO with a pop in the same cycle SHALL NOT accept a push: noc_in_ready depends on registered full only.
REQ-016 Counters SHALL be CNT_W wide with no wrap. cmd_beats=2^CNT_W-1 SHALL complete correctly.
REQ-017 Minimum throughput SHALL be one write per cycle when noc_in_valid and l2_gnt stay high.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, empty the FIFO, and zero the counters. Outputs SHALL then be 0 except cmd_ready=1, including while rst_n is low.
REQ-019 Reset mid-transfer SHALL abandon the transfer with no done pulse. Resetting the address unit is the owner's responsibility.

Structure
REQ-020 Package l2_wr_pkg SHALL hold the FSM state enum and the L2_ADDR_W=13 constant.
REQ-021 The FIFO SHALL be sub-module l2_wr_fifo2, a 2-entry, DATA_W-wide FIFO with push/pop/full/empty. All other logic SHALL live in l2_wr_ctrl.

Verification
REQ-022 The bench SHALL model the address unit as addr = 0x100 + k after the k-th advance (k=0 after initial_en), registered, and SHALL cover:
- cmd_beats=4, NoC and gnt always high -> writes to 0x100..0x103 in 4 consecutive cycles, done 1 cycle after the last write, busy low after.
- cmd_beats=3, gnt low for 2 cycles on the 2nd write -> l2_addr=0x101 and wdata held stable, 3 writes total, no duplicate address.
- cmd_beats=2, NoC offers 5 beats -> only 2 accepted, noc_in_ready low after the 2nd beat.
- cmd_beats=0 -> no initial_en, no l2_cs, done pulse 1 cycle after the handshake.
- rst_n pulsed low after the 2nd of 6 writes -> IDLE, cmd_ready=1, no done; a following cmd_beats=1 writes 0x100.
- noc_in_valid toggled 1/0 with gnt=1 -> FIFO never overflows, data order preserved.
